// File: rtl/pipe_status_ctrl_if.sv
// Control/status bundle for pipe_status_ctrl.
// master: run-control source (drives commands), slave: the controller.
interface pipe_status_ctrl_if #(
  parameter int NSTG  = 4,
  parameter int NSRC  = 2,
  parameter int STEPW = 16
);
  logic             init_calib_complete;
  logic             cpu_start;
  logic             step_cmd;
  logic [STEPW-1:0] step_num;
  logic             quit_cmd;
  logic [NSRC-1:0]  stall_req;
  logic             retire;
  logic             pc_start;
  logic             running;
  logic             stall;
  logic [NSTG-1:0]  stall_dly;
  logic             stall_1shot;
  logic [NSTG:0]    rst_pipe;
  logic             step_done;

  modport master (
    output init_calib_complete, cpu_start, step_cmd,
    output step_num, quit_cmd, stall_req, retire,
    input  pc_start, running, stall, stall_dly,
    input  stall_1shot, rst_pipe, step_done
  );

  modport slave (
    input  init_calib_complete, cpu_start, step_cmd,
    input  step_num, quit_cmd, stall_req, retire,
    output pc_start, running, stall, stall_dly,
    output stall_1shot, rst_pipe, step_done
  );
endinterface

// File: rtl/pipe_status_ctrl.sv
// Pipeline run/step/halt controller: FSM, stall fan-out, pipe flush.
// Ports: clk, rst_n (async low), bus (pipe_status_ctrl_if.slave).
module pipe_status_ctrl #(
  parameter int NSTG  = 4,
  parameter int NSRC  = 2,
  parameter int STEPW = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_status_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_PEND, S_RUN, S_STEP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_pend_step;
  logic [STEPW-1:0] r_pend_num;
  logic [STEPW-1:0] r_cnt;
  logic             r_pc_start;
  logic             r_step_done;
  logic [NSTG-1:0]  r_stall_dly;
  logic [NSTG:0]    r_rst_pipe;

  logic             w_expire;
  logic             w_run_now;
  logic             w_run_nxt;
  logic             w_stall;
  logic             w_pc_pend;
  logic             w_cal;
  logic             w_kill;
  logic [NSRC-1:0]  w_sreq;
  logic [STEPW-1:0] w_num;
  logic [STEPW-1:0] w_load;

  assign w_cal  = bus.init_calib_complete;
  assign w_sreq = bus.stall_req;
  // zero-length step still retires one instruction
  assign w_num  = (bus.step_num == '0) ? STEPW'(1)
                                       : bus.step_num;
  // entering STEP: fresh command wins over stored one
  assign w_load = bus.step_cmd ? w_num : r_pend_num;
  // forced exit from a running state
  assign w_kill = bus.quit_cmd | (~w_cal & w_run_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_expire = 1'b0;
    if (bus.quit_cmd) begin
      w_next = S_IDLE;
    end else if (!w_cal) begin
      if (w_run_now)
        w_next = S_IDLE;
      else if (bus.cpu_start || bus.step_cmd)
        w_next = S_PEND;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.cpu_start)     w_next = S_RUN;
          else if (bus.step_cmd) w_next = S_STEP;
        end
        S_PEND: begin
          if (bus.cpu_start)     w_next = S_RUN;
          else if (bus.step_cmd) w_next = S_STEP;
          else if (r_pend_step)  w_next = S_STEP;
          else                   w_next = S_RUN;
        end
        S_RUN: w_next = S_RUN;
        S_STEP: begin
          if (bus.retire && r_cnt == STEPW'(1)) begin
            w_next   = S_IDLE;
            w_expire = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_run_now = (r_state == S_RUN) || (r_state == S_STEP);
    w_run_nxt = (w_next == S_RUN) || (w_next == S_STEP);
    w_stall   = ~w_run_now | (|w_sreq);
    // PEND launches in the very cycle calibration arrives
    w_pc_pend = (r_state == S_PEND) & w_cal & ~bus.quit_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_step <= 1'b0;
      r_pend_num  <= '0;
    end else if (bus.quit_cmd) begin
      r_pend_step <= 1'b0;
      r_pend_num  <= '0;
    end else if (w_next == S_PEND) begin
      if (bus.cpu_start) begin
        r_pend_step <= 1'b0;
      end else if (bus.step_cmd) begin
        r_pend_step <= 1'b1;
        r_pend_num  <= w_num;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_kill) begin
      r_cnt <= '0;
    end else if (w_next == S_STEP && r_state != S_STEP) begin
      r_cnt <= w_load;
    end else if (r_state == S_STEP && bus.retire
                 && r_cnt != '0) begin
      r_cnt <= r_cnt - STEPW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_start  <= 1'b0;
      r_step_done <= 1'b0;
      r_stall_dly <= '1;
      r_rst_pipe  <= '0;
    end else begin
      r_pc_start  <= (r_state == S_IDLE) & w_run_nxt;
      r_step_done <= w_expire;
      r_stall_dly <= {r_stall_dly[NSTG-2:0], w_stall};
      r_rst_pipe  <= {r_rst_pipe[NSTG-1:0],
                      w_run_now ^ w_run_nxt};
    end
  end

  assign bus.pc_start    = r_pc_start | w_pc_pend;
  assign bus.running     = w_run_now;
  assign bus.stall       = w_stall;
  assign bus.stall_dly   = r_stall_dly;
  assign bus.stall_1shot = w_stall & ~r_stall_dly[0];
  assign bus.rst_pipe    = r_rst_pipe;
  assign bus.step_done   = r_step_done;
endmodule

// File: doc/pipe_status_ctrl.md
PIPE_STATUS_CTRL -- requirements
Module: pipe_status_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NSTG, 4, pipeline stages downstream of fetch (ID..WB); range 2-8.
- NSRC, 2, number of stall request sources; range 1-8.
- STEPW, 16, width of the step counter; range 4-32.
REQ-002 Ports, one per line: name  direction  width  meaning. Clock clk, reset rst_n, asynchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_calib_complete  in  1  memory calibrated; low forces halt
- cpu_start  in  1  start free run, 1-cycle pulse
- step_cmd  in  1  start step run, 1-cycle pulse
- step_num  in  STEPW  instructions to retire in step run, sampled with step_cmd
- quit_cmd  in  1  halt request, 1-cycle pulse
- stall_req  in  NSRC  per-source stall requests (D$, LSU, ...)
- retire  in  1  one instruction retired this cycle
- pc_start  out  1  load start PC, 1-cycle pulse
- running  out  1  state is RUN or STEP
- stall  out  1  global stall
- stall_dly  out  NSTG  bit i = stall delayed i+1 cycles
- stall_1shot  out  1  stall rising edge
- rst_pipe  out  NSTG+1  bit 0 pipeline flush pulse; bit i = bit 0 delayed i cycles
- step_done  out  1  step run completed, 1-cycle pulse

Function
REQ-003 FSM states IDLE, PEND, RUN, STEP; reset state IDLE.
REQ-004 Transition priority each cycle: quit_cmd > ~init_calib_complete > cpu_start > step_cmd > step-count expiry.
REQ-005 quit_cmd in any state -> IDLE next cycle; clears pending start.
REQ-006 init_calib_complete low: RUN/STEP -> IDLE; cpu_start or step_cmd received while low -> PEND, storing which mode (run/step) and step_num.
REQ-007 PEND -> RUN or STEP on first cycle init_calib_complete is high; pc_start high that same cycle.
REQ-008 IDLE + cpu_start with calib high -> RUN; IDLE + step_cmd with calib high -> STEP with counter = step_num; pc_start pulses cycle after entry (state registered, pc_start = entry edge).
REQ-009 cpu_start or step_cmd while RUN/STEP ignored; step_cmd with step_num = 0 treated as step_num = 1.
REQ-010 STEP: counter decrements on each retire; retire with counter = 1 -> IDLE next cycle, step_done pulses that next cycle; counter never wraps below 0.
REQ-011 stall = ~running | (|stall_req), combinational.
REQ-012 stall_dly shift chain: bit 0 <= stall, bit i <= bit i-1; all bits reset to 1.
REQ-013 stall_1shot = stall & ~stall_dly[0].
REQ-014 rst_pipe[0] registered, high one cycle after any IDLE/PEND -> RUN/STEP or RUN/STEP -> IDLE transition (incl. step expiry and calib loss); rst_pipe[i] <= rst_pipe[i-1]; reset 0.
REQ-015 running registered from state; exactly one pc_start per entry into RUN/STEP.
REQ-016 No combinational path from stall_req to any registered-only output (pc_start, running, rst_pipe, step_done, stall_dly).

Reset
REQ-017 rst_n low: state IDLE, counter 0, pending cleared, running 0, pc_start 0, step_done 0, stall_1shot 0, stall 1, stall_dly all 1, rst_pipe all 0.
REQ-018 rst_n low mid-STEP discards remaining count; no step_done issued.
REQ-019 Outputs after reset release depend only on inputs sampled from first rising clk edge onward.

Verification
REQ-020 calib=1, cpu_start at T -> running=1 at T+1, pc_start=1 at T+1 only, rst_pipe[0]=1 at T+1, rst_pipe[4]=1 at T+5 (NSTG=4), stall falls at T+1.
REQ-021 calib=0, cpu_start at T, calib rises at T+10 -> PEND held; pc_start=1 exactly at T+10; running=1 at T+11.
REQ-022 step_cmd step_num=3, retire pulses at 3 non-consecutive cycles -> running drops, step_done=1 one cycle after third retire; extra retire ignored.
REQ-023 RUN, stall_req=2'b10 for 3 cycles -> stall=1 3 cycles, stall_1shot=1 first cycle only, stall_dly[1] high 2 cycles later for 3 cycles.
REQ-024 RUN, quit_cmd and cpu_start same cycle -> IDLE, no pc_start, one rst_pipe[0] pulse.
REQ-025 rst_n asserted mid-STEP (counter=5) -> all outputs at REQ-017 values immediately, asynchronous; no step_done after release.
